mult_div: RTL and testbench
===========================

// Module: mult_div
// PURPOSE
//  Iterative signed multiply/divide unit for the multicycle CPU datapath. Consumes the
//  A and B register outputs on a start pulse from ctrl_unit; produces the HI and LO values
//  feeding the MEMtoReg mux (mfhi/mflo) and a div-by-zero flag to the exception logic.
//  Multiply uses radix-2 Booth; divide uses restoring division on magnitudes with sign fixup.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clock       in   1      system clock, rising edge
//  reset       in   1      synchronous, active-high
//  mult_start  in   1      1-cycle pulse: start signed multiply a_in*b_in
//  div_start   in   1      1-cycle pulse: start signed divide a_in/b_in
//  a_in        in   WIDTH  multiplicand / dividend (A_out)
//  b_in        in   WIDTH  multiplier / divisor (B_out)
//  hi_out      out  WIDTH  HI register: product[2W-1:W] or remainder
//  lo_out      out  WIDTH  LO register: product[W-1:0] or quotient
//  busy        out  1      operation in progress (state MULT or DIV)
//  done        out  1      1-cycle pulse: HI/LO valid with new result, or div-by-zero abort
//  div_zero    out  1      1-cycle pulse concurrent with done when divisor == 0
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; hi_out=lo_out=0; busy=done=div_zero=0;
//   internal counter/accumulators cleared. Reset mid-operation aborts; no result written.
//  States: IDLE, MULT, DIV, DONE.
//  - IDLE: mult_start -> latch operands, counter=0, MULT. div_start with b_in!=0 -> latch
//    |a|,|b| and result signs, DIV. div_start with b_in==0 -> DONE with div_zero=1, HI/LO
//    unchanged. Both starts same cycle: multiply wins, div_start dropped.
//  - MULT: one Booth step per cycle on {acc, multiplier, q-1}, arithmetic shift right;
//    after WIDTH steps write HI:LO = signed 2W-bit product, go DONE.
//  - DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit);
//    after WIDTH steps apply signs, write LO=quotient, HI=remainder, go DONE.
//  - DONE: done=1 for exactly this cycle; next cycle IDLE.
//  Latency: start sampled at edge 0 -> HI/LO updated and done high in cycle WIDTH+1 (33).
//   Div-by-zero: done and div_zero high in cycle 1.
//  busy=1 in MULT and DIV only. Starts while busy or in DONE are ignored (no queuing).
//  HI/LO change only on entry to DONE for a completed op; hold otherwise.
//  Div semantics (MIPS): quotient truncates toward zero; remainder takes dividend's sign.
//   -2^(W-1) / -1: LO=0x80000000, HI=0, no flag. Magnitude of -2^(W-1) held in W+1 bits.
//  Operands latched at start; a_in/b_in changes during busy have no effect.
// STRUCTURE
//  Package cpu_pkg: md_state_t enum {IDLE,MULT,DIV,DONE}; MD_WIDTH=32 constant.
//  Sub-module div_step (combinational): one restoring iteration
//   (rem_in, quo_in, divisor) -> (rem_out, quo_out). Booth step stays inline.
//  Counter: $clog2(WIDTH)+1 bits; terminal at WIDTH-1.
// TESTING
//  1 mult_start a=7 b=0xFFFFFFFD(-3) -> cycle 33: HI=0xFFFFFFFF LO=0xFFFFFFEB, done 1 cyc.
//  2 mult_start a=b=0x80000000 -> HI=0x40000000 LO=0x00000000; busy high cycles 1..32.
//  3 div_start a=0xFFFFFFF9(-7) b=2 -> LO=0xFFFFFFFD(-3) HI=0xFFFFFFFF(-1) at cycle 33.
//  4 HI/LO preloaded by test 3; div_start a=5 b=0 -> cycle 1: done=div_zero=1, HI/LO held.
//  5 div_start a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000 HI=0, div_zero=0.
//  6 mult_start 3*4, pulse div_start at cycle 5, reset at cycle 10 -> div ignored;
//    after reset busy=done=0, HI=LO=0; no done pulse follows.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle CPU datapath blocks.
package cpu_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// The incoming remainder is always below the divisor, so it fits in WIDTH bits;
// only the shifted partial remainder needs the extra bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Shift next dividend bit in, trial subtract, keep result if it did not go negative
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor});
        // Exact when fits: the true difference is below divisor < 2^WIDTH
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = fits ? diff : shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mult_div.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, sign fixup)
// producing HI/LO for mfhi/mflo and a div-by-zero pulse for exceptions.
// The acc/mq/mcand registers are shared: Booth uses {acc, mq, q_1} with
// mcand as multiplicand; divide uses acc as remainder, mq as dividend/quotient
// and mcand as divisor magnitude.
module mult_div
    import cpu_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t        state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;      // one guard bit so Booth add/sub never overflows
    logic [WIDTH:0]   mcand;
    logic [WIDTH-1:0] mq;
    logic             q_1;
    logic             neg_q, neg_r, dz_q;
    logic             last;
    logic             b_zero;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_mq;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign b_zero = (b_in == '0);
    assign a_mag  = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    assign b_mag  = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

    assign busy     = (state == MULT) || (state == DIV);
    assign done     = (state == DONE);
    assign div_zero = (state == DONE) && dz_q;

    // Booth step: add/sub multiplicand per {q0, q-1}, then arithmetic shift right
    always_comb begin
        booth_sum = acc;
        case ({mq[0], q_1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
        booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_mq  = {booth_sum[0], mq[WIDTH-1:1]};
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (acc[WIDTH-1:0]),
        .quo_in  (mq),
        .divisor (mcand[WIDTH-1:0]),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: multiply wins over divide; starts outside IDLE are ignored
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (mult_start)     state_nx = MULT;
                else if (div_start) state_nx = b_zero ? DONE : DIV;
            end
            MULT:    if (last) state_nx = DONE;
            DIV:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand latch, per-cycle iteration, HI/LO write on completion
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mq     <= '0;
            q_1    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_q   <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            dz_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    acc <= '0;
                    q_1 <= 1'b0;
                    if (mult_start) begin
                        mcand <= {a_in[WIDTH-1], a_in};
                        mq    <= b_in;
                    end else if (div_start) begin
                        dz_q  <= b_zero;
                        mcand <= {1'b0, b_mag};
                        mq    <= a_mag;
                        neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        neg_r <= a_in[WIDTH-1];
                    end
                end
                MULT: begin
                    cnt <= cnt + 1'b1;
                    acc <= booth_acc;
                    mq  <= booth_mq;
                    q_1 <= mq[0];
                    if (last) begin
                        hi_out <= booth_acc[WIDTH-1:0];
                        lo_out <= booth_mq;
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    acc <= {1'b0, rem_nx};
                    mq  <= quo_nx;
                    // Quotient truncates toward zero; remainder follows dividend sign
                    if (last) begin
                        lo_out <= neg_q ? (~quo_nx + 1'b1) : quo_nx;
                        hi_out <= neg_r ? (~rem_nx + 1'b1) : rem_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: hand-computed results, latency, busy window,
// div-by-zero abort, overflow case and reset-abort behaviour.
module tb_mult_div;

    logic        clock = 1'b0;
    logic        reset;
    logic        mult_start, div_start;
    logic [31:0] a_in, b_in;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mult_div #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a_in       (a_in),
        .b_in       (b_in),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op at the current cycle (sampled at edge 0), scramble operands
    // afterwards, and observe until done or the cycle budget runs out.
    task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                          output int dcyc, output int bcnt, output logic dz,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output logic done_after);
        dcyc = 0; bcnt = 0; dz = 1'b0; hi = '0; lo = '0; done_after = 1'b0;
        a_in = a; b_in = b;
        if (is_div) div_start = 1'b1;
        else        mult_start = 1'b1;
        @(posedge clock); #1;
        mult_start = 1'b0; div_start = 1'b0;
        a_in = 32'hDEADBEEF; b_in = 32'h0;
        for (int c = 1; c <= 40 && dcyc == 0; c++) begin
            if (busy) bcnt++;
            if (done) begin
                dcyc = c; dz = div_zero; hi = hi_out; lo = lo_out;
            end
            @(posedge clock); #1;
        end
        done_after = done;
    endtask

    initial begin
        int          dcyc, bcnt, seen;
        logic        dz, da;
        logic [31:0] hi, lo;

        reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_hi",   hi_out, 0);
        chk("rst_lo",   lo_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz",   div_zero, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 1: 7 * -3 = -21
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, dcyc, bcnt, dz, hi, lo, da);
        chk("t1_lat",  dcyc, 33);
        chk("t1_hi",   hi, 32'hFFFFFFFF);
        chk("t1_lo",   lo, 32'hFFFFFFEB);
        chk("t1_dz",   dz, 0);
        chk("t1_1cyc", da, 0);

        // 2: -2^31 * -2^31 = 2^62
        run_op(1'b0, 32'h80000000, 32'h80000000, dcyc, bcnt, dz, hi, lo, da);
        chk("t2_lat",  dcyc, 33);
        chk("t2_hi",   hi, 32'h40000000);
        chk("t2_lo",   lo, 32'h00000000);
        chk("t2_busy", bcnt, 32);

        // 3: -7 / 2 = -3 rem -1
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, dcyc, bcnt, dz, hi, lo, da);
        chk("t3_lat",  dcyc, 33);
        chk("t3_lo",   lo, 32'hFFFFFFFD);
        chk("t3_hi",   hi, 32'hFFFFFFFF);
        chk("t3_dz",   dz, 0);
        chk("t3_busy", bcnt, 32);

        // 4: 5 / 0 aborts in cycle 1, HI/LO keep test 3 values
        run_op(1'b1, 32'd5, 32'd0, dcyc, bcnt, dz, hi, lo, da);
        chk("t4_lat",  dcyc, 1);
        chk("t4_dz",   dz, 1);
        chk("t4_hi",   hi, 32'hFFFFFFFF);
        chk("t4_lo",   lo, 32'hFFFFFFFD);
        chk("t4_busy", bcnt, 0);
        chk("t4_1cyc", da, 0);
        chk("t4_dz_clr", div_zero, 0);

        // 5: -2^31 / -1 wraps, no flag
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, dcyc, bcnt, dz, hi, lo, da);
        chk("t5_lat", dcyc, 33);
        chk("t5_lo",  lo, 32'h80000000);
        chk("t5_hi",  hi, 32'h00000000);
        chk("t5_dz",  dz, 0);

        // 6: 3*4 started, stray div_start at cycle 5, reset at cycle 10
        a_in = 32'd3; b_in = 32'd4; mult_start = 1'b1;
        @(posedge clock); #1;
        mult_start = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        a_in = 32'd100; b_in = 32'd0; div_start = 1'b1;
        @(posedge clock); #1;
        div_start = 1'b0;
        chk("t6_busy_c6", busy, 1);
        chk("t6_dz_c6", div_zero, 0);
        repeat (4) begin @(posedge clock); #1; end
        chk("t6_busy_c10", busy, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_hi",   hi_out, 0);
        chk("t6_lo",   lo_out, 0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) seen++;
            @(posedge clock); #1;
        end
        chk("t6_quiet", seen, 0);
        chk("t6_lo_hold", lo_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
